psum_quant_out: RTL and testbench

//  Output stage directly downstream of the MAC accumulator. Captures each finished signed partial sum (MACCNV_Mac) as the MAC raises its finish level.

---
 rtl/psum_quant_out_pkg.sv | 31 +++
 rtl/psum_quant_out_if.sv | 34 +++
 rtl/psum_quant_out_fifo.sv | 69 ++++++
 rtl/psum_quant_out.sv | 152 +++++++++++++++
 tb/tb_psum_quant_out.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_quant_out_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psum_quant_out_pkg : widths, log2 helper and FSM encoding shared with MAC |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package psum_quant_out_pkg;

  function automatic int C_LOG_2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res = res + 1;
    return res;
  endfunction

  localparam int DATA_WIDTH  = 8;
  localparam int BLOCK_DEPTH = 32;
  localparam int PSUM_WIDTH  = 2 * DATA_WIDTH + C_LOG_2(BLOCK_DEPTH * 3);
  localparam int FIFO_DEPTH  = 4;
  localparam int CNT_WIDTH   = 12;
  localparam int SHIFT_WIDTH = 5;
  localparam int FIFO_CNT_W  = C_LOG_2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/psum_quant_out_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psum_quant_out_if : tile control, psum input and result output bundle     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface psum_quant_out_if;
  import psum_quant_out_pkg::*;

  logic                          sta;
  logic [SHIFT_WIDTH-1:0]        cfg_shift;
  logic                          cfg_relu;
  logic [CNT_WIDTH-1:0]          cfg_num;
  logic                          psum_val;
  logic signed [PSUM_WIDTH-1:0]  psum;
  logic                          psum_rdy;
  logic                          out_val;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_last;
  logic                          out_rdy;
  logic                          done;
  logic                          busy;

  modport master (
    output sta, cfg_shift, cfg_relu, cfg_num, psum_val, psum, out_rdy,
    input  psum_rdy, out_val, out_data, out_last, done, busy
  );

  modport slave (
    input  sta, cfg_shift, cfg_relu, cfg_num, psum_val, psum, out_rdy,
    output psum_rdy, out_val, out_data, out_last, done, busy
  );

endinterface
`default_nettype wire

// File: rtl/psum_quant_out_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psum_fifo : synchronous first-word-fall-through FIFO holding data + last  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module psum_fifo
  import psum_quant_out_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en_i,
  input  logic [DW-1:0]                 wr_data_i,
  input  logic                          wr_last_i,
  input  logic                          rd_en_i,
  output logic                          rd_val_o,
  output logic [DW-1:0]                 rd_data_o,
  output logic                          rd_last_o,
  output logic [C_LOG_2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = C_LOG_2(DEPTH);
  localparam int CW = C_LOG_2(DEPTH + 1);

  logic [DW:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, rd_fire, bypass, push, pop;

  // An empty FIFO presents the incoming word directly, so a write can leave
  // in the same cycle without ever being stored.
  assign empty     = (count_q == '0);
  assign rd_val_o  = !empty || wr_en_i;
  assign {rd_last_o, rd_data_o} = empty ? {wr_last_i, wr_data_i} : mem_q[rd_ptr_q];
  assign rd_fire   = rd_en_i && rd_val_o;
  assign bypass    = empty && wr_en_i && rd_fire;
  assign push      = wr_en_i && !bypass;
  assign pop       = rd_fire && !empty;
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_last_i, wr_data_i};
  end

endmodule
`default_nettype wire

// File: rtl/psum_quant_out.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psum_quant_out : shift / ReLU / saturate MAC partial sums into a FIFO     |
// | Option macro PSUM_ROUND_EN adds round-half-up before the shift. Rev 1.0   |
// +--------------------------------------------------------------------------+
module psum_quant_out
  import psum_quant_out_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  psum_quant_out_if.slave  bus
);
  localparam int EXT_W = PSUM_WIDTH + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(2 ** (DATA_WIDTH - 1)));

  state_e                   state_q, state_d;
  logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
  logic                     relu_q, relu_d;
  logic [CNT_WIDTH-1:0]     num_q, num_d;
  logic [CNT_WIDTH-1:0]     in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0]     out_cnt_q, out_cnt_d;

  logic                     s1_val_q, s1_last_q;
  logic signed [EXT_W-1:0]  s1_data_q;
  logic                     s2_val_q, s2_last_q;
  logic [DATA_WIDTH-1:0]    s2_data_q;

  logic [FIFO_CNT_W-1:0]    fifo_count;
  logic [FIFO_CNT_W:0]      occupancy;
  logic                     psum_rdy, accept, out_hs;
  logic signed [EXT_W-1:0]  ext_w, biased_w, shifted_w, relu_w;
  logic [DATA_WIDTH-1:0]    sat_w;

  // Credit check counts both pipeline stages so every accepted psum has a slot.
  assign occupancy = {1'b0, fifo_count} + (FIFO_CNT_W+1)'(s1_val_q) + (FIFO_CNT_W+1)'(s2_val_q);
  assign psum_rdy  = (state_q == ST_RUN) && (occupancy < (FIFO_CNT_W+1)'(FIFO_DEPTH));
  assign accept    = bus.psum_val && psum_rdy;
  assign out_hs    = bus.out_val && bus.out_rdy;

  assign bus.psum_rdy = psum_rdy;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.busy     = (state_q != ST_IDLE);

  assign ext_w = {bus.psum[PSUM_WIDTH-1], bus.psum};
`ifdef PSUM_ROUND_EN
  logic [EXT_W-1:0] round_w;
  assign round_w  = (shift_q != '0) ? (EXT_W'(1) << (shift_q - SHIFT_WIDTH'(1))) : '0;
  assign biased_w = ext_w + $signed(round_w);
`else
  assign biased_w = ext_w;
`endif
  assign shifted_w = biased_w >>> shift_q;

  always_comb begin
    relu_w = (relu_q && s1_data_q[EXT_W-1]) ? '0 : s1_data_q;
    if (relu_w > SAT_MAX)      sat_w = SAT_MAX[DATA_WIDTH-1:0];
    else if (relu_w < SAT_MIN) sat_w = SAT_MIN[DATA_WIDTH-1:0];
    else                       sat_w = relu_w[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    num_d     = num_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (accept) in_cnt_d  = in_cnt_q + CNT_WIDTH'(1);
    if (out_hs) out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.sta) begin
          state_d   = ST_RUN;
          shift_d   = bus.cfg_shift;
          relu_d    = bus.cfg_relu;
          num_d     = bus.cfg_num;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      ST_RUN:   if (accept && (in_cnt_d == num_q)) state_d = ST_DRAIN;
      ST_DRAIN: if (out_hs && (out_cnt_d == num_q)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      num_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      num_q     <= num_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_val_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_data_q <= '0;
      s2_val_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_data_q <= '0;
    end else begin
      s1_val_q <= accept;
      s2_val_q <= s1_val_q;
      if (accept) begin
        s1_data_q <= shifted_w;
        s1_last_q <= (in_cnt_q == (num_q - CNT_WIDTH'(1)));
      end
      if (s1_val_q) begin
        s2_data_q <= sat_w;
        s2_last_q <= s1_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_IDLE) && bus.sta) begin
      assert (bus.cfg_num != '0);
    end
  end

  psum_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (s2_val_q),
    .wr_data_i (s2_data_q),
    .wr_last_i (s2_last_q),
    .rd_en_i   (bus.out_rdy),
    .rd_val_o  (bus.out_val),
    .rd_data_o (bus.out_data),
    .rd_last_o (bus.out_last),
    .count_o   (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_psum_quant_out.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_psum_quant_out : directed tiles with a scoreboard of expected results  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_psum_quant_out;
  import psum_quant_out_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   cyc      = 0;
  int   last_hs_cyc = 0;
  int   cur_shift, cur_num, idx;
  bit   cur_relu;
  exp_t sb[$];

  psum_quant_out_if bus ();

  psum_quant_out dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input int p, input int sh, input bit relu);
    longint y;
    y = p;
`ifdef PSUM_ROUND_EN
    if (sh > 0) y = y + (longint'(1) << (sh - 1));
`endif
    y = y >>> sh;
    if (relu && y < 0) y = 0;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y[7:0];
  endfunction

  // Result monitor: every output handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_val && bus.out_rdy) begin
      exp_t e;
      n_out++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e.d));
        check("out_last", 32'(bus.out_last), 32'(e.l));
        if (bus.out_last) last_hs_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input int p);
    exp_t e;
    e.d = model(p, cur_shift, cur_relu);
    e.l = (idx == cur_num - 1);
    sb.push_back(e);
    idx++;
  endtask

  task automatic start_tile(input int sh, input bit relu, input int num);
    bus.cfg_shift = 5'(sh);
    bus.cfg_relu  = relu;
    bus.cfg_num   = 12'(num);
    bus.sta       = 1'b1;
    tick();
    bus.sta   = 1'b0;
    cur_shift = sh;
    cur_relu  = relu;
    cur_num   = num;
    idx       = 0;
    check("busy_after_sta", 32'(bus.busy), 32'd1);
  endtask

  task automatic send(input int p);
    int n;
    n = 0;
    while (!bus.psum_rdy && n < 50) begin
      tick();
      n++;
    end
    check("psum_rdy_wait", 32'(bus.psum_rdy), 32'd1);
    bus.psum_val = 1'b1;
    bus.psum     = PSUM_WIDTH'(p);
    push_exp(p);
    tick();
    bus.psum_val = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
    check("done_after_last_hs", 32'(cyc - last_hs_cyc), 32'd1);
    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int acc;
    int outs0;
    rst_n         = 1'b0;
    bus.sta       = 1'b0;
    bus.cfg_shift = '0;
    bus.cfg_relu  = 1'b0;
    bus.cfg_num   = '0;
    bus.psum_val  = 1'b0;
    bus.psum      = '0;
    bus.out_rdy   = 1'b0;
    tick();
    tick();
    check("rst_out_val",  32'(bus.out_val),  32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_psum_rdy", 32'(bus.psum_rdy), 32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    rst_n = 1'b1;
    tick();

    // Basic shift plus two-cycle latency.
    bus.out_rdy = 1'b1;
    start_tile(2, 1'b0, 1);
    send(30);
    check("lat_cycle1_out_val", 32'(bus.out_val), 32'd0);
    tick();
    check("lat_cycle2_out_val", 32'(bus.out_val), 32'd1);
    wait_done();

    // Saturation, then saturation with ReLU.
    start_tile(0, 1'b0, 3);
    send(5000);
    send(-5000);
    send(100);
    wait_done();
    start_tile(0, 1'b1, 2);
    send(5000);
    send(-5000);
    wait_done();

    // Negative value rounding direction.
    start_tile(4, 1'b0, 2);
    send(-291);
    send(30);
    wait_done();

    // Back-pressure: four credits, then drain in order.
    bus.out_rdy = 1'b0;
    outs0 = n_out;
    start_tile(0, 1'b0, 6);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.psum_val = 1'b1;
      bus.psum     = PSUM_WIDTH'(10 + acc);
      if (bus.psum_rdy) begin
        push_exp(10 + acc);
        acc++;
      end
      tick();
    end
    bus.psum_val = 1'b0;
    check("accepts_before_stall", 32'(acc), 32'd4);
    check("psum_rdy_stalled", 32'(bus.psum_rdy), 32'd0);
    bus.out_rdy = 1'b1;
    send(14);
    send(15);
    wait_done();
    check("bp_output_count", 32'(n_out - outs0), 32'd6);

    // Last tag on third output; psum in IDLE is dropped.
    start_tile(1, 1'b0, 3);
    send(9);
    tick();
    tick();
    send(-7);
    send(200);
    wait_done();
    outs0 = n_out;
    bus.psum_val = 1'b1;
    bus.psum     = PSUM_WIDTH'(77);
    tick();
    tick();
    tick();
    bus.psum_val = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("idle_psum_dropped", 32'(n_out - outs0), 32'd0);
    check("idle_psum_rdy", 32'(bus.psum_rdy), 32'd0);

    // Reset mid-tile, then a clean tile that ignores a second sta.
    bus.out_rdy = 1'b0;
    start_tile(0, 1'b0, 5);
    send(1);
    send(2);
    tick();
    tick();
    tick();
    check("held_before_reset", 32'(bus.out_val), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_out_val",  32'(bus.out_val),  32'd0);
    check("mid_rst_busy",     32'(bus.busy),     32'd0);
    check("mid_rst_psum_rdy", 32'(bus.psum_rdy), 32'd0);
    sb.delete();
    bus.out_rdy = 1'b1;
    start_tile(3, 1'b0, 2);
    bus.cfg_shift = 5'd0;
    bus.cfg_relu  = 1'b1;
    bus.cfg_num   = 12'd1;
    bus.sta       = 1'b1;
    tick();
    bus.sta = 1'b0;
    send(100);
    send(-100);
    wait_done();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
